fp_norm_round: RTL

Post-add normalizer and rounder for the single-precision FP adder datapath; the inverse-direction partner of the 27-bit leading-zero priority encoder. It consumes the raw 27-bit adder magnitude with the encoder's shift count and zero flag. It applies the left shift (or the 1-bit right shift on carry-out), adjusts the exponent, rounds to nearest-even and packs an IEEE-754 binary32 word. Two-stage valid/ready pipeline between the adder core and the result register.

---
 rtl/fp32_pkg.sv | 23 ++
 rtl/fp_round_rne.sv | 77 +++++++
 rtl/fp_norm_round.sv | 80 ++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared binary32 constants and the stage-1 payload type for the post-add
// normalizer/rounder datapath.
package fp32_pkg;

  localparam int unsigned EXP_W   = 8;
  localparam int unsigned FRAC_W  = 23;
  localparam int unsigned MANT_W  = 27;
  localparam int unsigned BIAS    = 127;
  localparam int unsigned EXP_MAX = 255;

  // Internal exponent is two's complement so post-shift underflow is visible.
  localparam int unsigned EXP10_W = 10;
  localparam int unsigned SHAMT_W = 5;

  // Normalized beat held between shift/adjust and round/pack.
  typedef struct packed {
    logic               sign;
    logic [EXP10_W-1:0] exp10;   // signed value, stored as raw bits
    logic [MANT_W-1:0]  mant27;  // [26] hidden, [25:3] frac, [2] G, [1] R, [0] S
    logic               is_zero;
  } s1_payload_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even and binary32 pack.
// Ports:
//   sign, exp10 (signed biased exponent), mant (normalized 27-bit G/R/S mantissa),
//   is_zero (exact zero) -> result_c (packed binary32).
// Macro FP_NORM_DENORM_EN: defined = gradual underflow, undefined = flush to zero.
module fp_round_rne
  import fp32_pkg::*;
(
  input  logic               sign,
  input  logic [EXP10_W-1:0] exp10,
  input  logic [MANT_W-1:0]  mant,
  input  logic               is_zero,
  output logic [31:0]        result_c
);

  logic signed [EXP10_W-1:0] exp_s;
  logic signed [EXP10_W-1:0] exp_r;
  logic                      denorm;
  logic [MANT_W-1:0]         mant_r;
  logic                      round_up;
  logic [FRAC_W+1:0]         sig;

  assign exp_s  = $signed(exp10);
  // Underflow is judged on the pre-rounding exponent.
  assign denorm = (exp_s <= 10'sd0);

`ifdef FP_NORM_DENORM_EN
  logic signed [EXP10_W-1:0] dist;
  logic [SHAMT_W-1:0]        shift;
  logic [MANT_W-1:0]         lost_mask;

  // Denormalize: shift right by (1 - exp), folding lost bits into sticky.
  always_comb begin
    dist      = 10'sd1 - exp_s;
    shift     = '0;
    lost_mask = '0;
    mant_r    = mant;
    if (denorm) begin
      shift     = (dist > 10'sd27) ? 5'd27 : dist[SHAMT_W-1:0];
      lost_mask = MANT_W'((28'd1 << shift) - 28'd1);
      mant_r    = mant >> shift;
      mant_r[0] = mant_r[0] | (|(mant & lost_mask));
    end
  end
`else
  logic sig_hidden_unused;

  assign mant_r            = mant;
  assign sig_hidden_unused = sig[FRAC_W];
`endif

  // RNE: round up on G unless it is an exact tie with an even LSB.
  assign round_up = mant_r[2] & (mant_r[1] | mant_r[0] | mant_r[3]);
  assign sig      = {1'b0, mant_r[MANT_W-1:3]} + (FRAC_W+2)'(round_up);
  // A carry out of the 24-bit significand leaves sig = 1.0 and bumps exponent.
  assign exp_r    = exp_s + $signed({{(EXP10_W-1){1'b0}}, sig[FRAC_W+1]});

  // Pack with priority: exact zero, underflow, overflow to Inf, normal.
  always_comb begin
    result_c = '0;
    if (is_zero) begin
      result_c = '0;
    end else if (denorm) begin
`ifdef FP_NORM_DENORM_EN
      // sig[23] set after rounding means the value reached the smallest normal.
      result_c = {sign, 7'd0, sig[FRAC_W:0]};
`else
      result_c = {sign, 31'd0};
`endif
    end else if (exp_r >= $signed(EXP10_W'(EXP_MAX))) begin
      result_c = {sign, EXP_W'(EXP_MAX), 23'd0};
    end else begin
      result_c = {sign, exp_r[EXP_W-1:0], sig[FRAC_W-1:0]};
    end
  end

endmodule

// File: rtl/fp_norm_round.sv
// Post-add normalizer and rounder: two-stage valid/ready pipeline that shifts
// the raw adder magnitude, adjusts the exponent, rounds RNE and packs binary32.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ready, in_sign, in_exp, in_cout, in_mant, in_shamt, in_zero
//   out_valid/out_ready, out_result
// Macro FP_NORM_DENORM_EN (in fp_round_rne) selects gradual underflow.
module fp_norm_round
  import fp32_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W-1:0]   in_exp,
  input  logic               in_cout,
  input  logic [MANT_W-1:0]  in_mant,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic               in_zero,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_result
);

  s1_payload_t s1_d;
  s1_payload_t s1_q;
  logic        s1_valid;
  logic        s1_advance;
  logic        s2_open;
  logic [31:0] rnd_result_c;

  // Shift/adjust: carry-out takes a 1-bit right shift, else normalize left.
  always_comb begin
    s1_d      = '0;
    s1_d.sign = in_sign;
    if (in_cout) begin
      s1_d.mant27 = {1'b1, in_mant[MANT_W-1:2], in_mant[1] | in_mant[0]};
      s1_d.exp10  = EXP10_W'(in_exp) + 10'd1;
    end else begin
      s1_d.mant27 = in_mant << in_shamt;
      s1_d.exp10  = EXP10_W'(in_exp) - EXP10_W'(in_shamt);
    end
    s1_d.is_zero = in_zero & ~in_cout;
  end

  // Handshake: each stage advances when the next is empty or draining.
  assign s2_open    = ~out_valid | out_ready;
  assign s1_advance = s1_valid & s2_open;
  assign in_ready   = ~s1_valid | s1_advance;

  fp_round_rne u_round (
    .sign     (s1_q.sign),
    .exp10    (s1_q.exp10),
    .mant     (s1_q.mant27),
    .is_zero  (s1_q.is_zero),
    .result_c (rnd_result_c)
  );

  // Pipeline registers; payloads only load with a valid beat so a stalled
  // result stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_q       <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_open) begin
        out_valid <= s1_valid;
        if (s1_valid) out_result <= rnd_result_c;
      end
    end
  end

endmodule
